// File: rtl/mini_alu_core_p.sv
// mini_alu_core_p: two-stage (fetch/execute) parametrised ALU microcontroller
// with shift-add MUL, CALL/RET return stack and stalled VGA handshake.
//
// Ports:
//   Clock, Reset        rising-edge clock, async active-low reset
//   oIP / iInstruction  ROM address out, ROM word in ({op,dst,src1,src0})
//   oLed                LED register
//   oVGAValid/iVGAReady video write handshake; oVGAAddr/oVGAColor payload
//   oBusy               execute stage stalled (MUL or VGA)
//   oStackErr/oIllegal  sticky error flags, cleared only by Reset
module mini_alu_core_p #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int IP_WIDTH       = 16,
  parameter int STACK_DEPTH    = 4,
  parameter int VGA_ADDR_WIDTH = 19,
  parameter int LED_WIDTH      = 8
) (
  input  logic                      Clock,
  input  logic                      Reset,
  output logic [IP_WIDTH-1:0]       oIP,
  input  logic [3+3*ADDR_WIDTH:0]   iInstruction,
  output logic [LED_WIDTH-1:0]      oLed,
  output logic                      oVGAValid,
  input  logic                      iVGAReady,
  output logic [VGA_ADDR_WIDTH-1:0] oVGAAddr,
  output logic [2:0]                oVGAColor,
  output logic                      oBusy,
  output logic                      oStackErr,
  output logic                      oIllegal
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int CNW = $clog2(DATA_WIDTH + 1);

  localparam logic [3:0] OP_LED  = 4'h1;
  localparam logic [3:0] OP_BLE  = 4'h2;
  localparam logic [3:0] OP_STO  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_VGA  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_CALL = 4'h9;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;

  typedef enum logic {S_IDLE, S_RUN} mul_st_t;

  logic [3+3*ADDR_WIDTH:0] r_ir;
  logic [DATA_WIDTH-1:0]   r_rf [2**ADDR_WIDTH];
  logic [IP_WIDTH-1:0]     r_stack [STACK_DEPTH];
  logic [SPW-1:0]          r_sp;

  mul_st_t               r_state;
  mul_st_t               w_next;
  logic [DATA_WIDTH-1:0] r_ma;
  logic [DATA_WIDTH-1:0] r_mb;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CNW-1:0]        r_cnt;

  logic [3:0]            w_op;
  logic [ADDR_WIDTH-1:0] w_dst;
  logic [ADDR_WIDTH-1:0] w_s1;
  logic [ADDR_WIDTH-1:0] w_s0;
  logic [DATA_WIDTH-1:0] w_rs1;
  logic [DATA_WIDTH-1:0] w_rs0;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [DATA_WIDTH-1:0] w_acc_nxt;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [IP_WIDTH-1:0]   w_tgt;
  logic [SIW-1:0]        w_push_idx;
  logic [SIW-1:0]        w_top_idx;
  logic w_is_led, w_is_ble, w_is_sto, w_is_add, w_is_jmp, w_is_vga;
  logic w_is_sub, w_is_mul, w_is_call, w_is_ret, w_is_beq, w_is_ill;
  logic w_full, w_empty, w_take, w_we, w_last, w_stall;

  assign w_op  = r_ir[3+3*ADDR_WIDTH -: 4];
  assign w_dst = r_ir[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign w_s1  = r_ir[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign w_s0  = r_ir[ADDR_WIDTH-1:0];

  assign w_rs1 = r_rf[w_s1];
  assign w_rs0 = r_rf[w_s0];
  assign w_imm = DATA_WIDTH'({w_s1, w_s0});

  assign w_is_led  = (w_op == OP_LED);
  assign w_is_ble  = (w_op == OP_BLE);
  assign w_is_sto  = (w_op == OP_STO);
  assign w_is_add  = (w_op == OP_ADD);
  assign w_is_jmp  = (w_op == OP_JMP);
  assign w_is_vga  = (w_op == OP_VGA);
  assign w_is_sub  = (w_op == OP_SUB);
  assign w_is_mul  = (w_op == OP_MUL);
  assign w_is_call = (w_op == OP_CALL);
  assign w_is_ret  = (w_op == OP_RET);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_ill  = (w_op >= 4'hC);

  assign w_full     = (r_sp == SPW'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = SIW'(r_sp);
  assign w_top_idx  = SIW'(r_sp - 1'b1);

  // MUL releases the pipeline on its last RUN cycle, so the
  // following instruction lands in IR on the writeback edge.
  assign w_last  = (r_state == S_RUN) &&
                   (r_cnt == CNW'(DATA_WIDTH - 1));
  assign w_stall = (w_is_mul & ~w_last) |
                   (w_is_vga & ~iVGAReady);

  assign oBusy     = w_is_mul | (w_is_vga & ~iVGAReady);
  assign oVGAValid = w_is_vga;
  assign oVGAAddr  = w_is_vga ?
                     VGA_ADDR_WIDTH'({w_rs1, w_rs0}) : '0;
  assign oVGAColor = w_is_vga ? w_dst[ADDR_WIDTH-1 -: 3] : '0;

  assign w_acc_nxt = r_acc + (r_mb[0] ? r_ma : '0);

  always_comb begin
    w_take = 1'b0;
    w_tgt  = IP_WIDTH'(w_dst);
    unique case (1'b1)
      w_is_jmp:  w_take = 1'b1;
      w_is_ble:  w_take = (w_rs1 <= w_rs0);
      w_is_beq:  w_take = (w_rs1 == w_rs0);
      w_is_call: w_take = ~w_full;
      w_is_ret: begin
        w_take = ~w_empty;
        w_tgt  = r_stack[w_top_idx];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_wdata = w_imm;
    unique case (1'b1)
      w_is_sto: w_we = 1'b1;
      w_is_add: begin
        w_we    = 1'b1;
        w_wdata = w_rs1 + w_rs0;
      end
      w_is_sub: begin
        w_we    = 1'b1;
        w_wdata = w_rs1 - w_rs0;
      end
      w_is_mul: begin
        w_we    = w_last;
        w_wdata = w_acc_nxt;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_is_mul) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_ma  <= '0;
      r_mb  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_ma  <= w_rs1;
      r_mb  <= w_rs0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      r_ma  <= r_ma << 1;
      r_mb  <= r_mb >> 1;
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (w_we) r_rf[w_dst] <= w_wdata;
  end

  always_ff @(posedge Clock) begin
    if (w_is_call && !w_full) r_stack[w_push_idx] <= oIP;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oIP       <= '0;
      r_ir      <= '0;
      oLed      <= '0;
      oStackErr <= 1'b0;
      oIllegal  <= 1'b0;
      r_sp      <= '0;
    end else if (!w_stall) begin
      if (w_take) begin
        oIP  <= w_tgt;
        r_ir <= '0;
      end else begin
        oIP  <= oIP + 1'b1;
        r_ir <= iInstruction;
      end
      if (w_is_led) oLed <= w_rs1[LED_WIDTH-1:0];
      if (w_is_ill) oIllegal <= 1'b1;
      if (w_is_call) begin
        if (w_full) oStackErr <= 1'b1;
        else        r_sp <= r_sp + 1'b1;
      end
      if (w_is_ret) begin
        if (w_empty) oStackErr <= 1'b1;
        else         r_sp <= r_sp - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mini_alu_core_p.sv
// tb_mini_alu_core_p: directed scoreboard bench for mini_alu_core_p
// (STACK_DEPTH=2, other parameters at their defaults).
module tb_mini_alu_core_p;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] oIP;
  logic [27:0] iInstruction;
  logic [7:0]  oLed;
  logic        oVGAValid;
  logic        iVGAReady = 1'b1;
  logic [18:0] oVGAAddr;
  logic [2:0]  oVGAColor;
  logic        oBusy;
  logic        oStackErr;
  logic        oIllegal;

  logic [27:0] rom [256];
  assign iInstruction = (oIP < 16'd256) ? rom[oIP[7:0]] : '0;

  always #5 Clock = ~Clock;

  mini_alu_core_p #(.STACK_DEPTH(2)) dut (
    .Clock(Clock), .Reset(Reset), .oIP(oIP),
    .iInstruction(iInstruction), .oLed(oLed),
    .oVGAValid(oVGAValid), .iVGAReady(iVGAReady),
    .oVGAAddr(oVGAAddr), .oVGAColor(oVGAColor),
    .oBusy(oBusy), .oStackErr(oStackErr), .oIllegal(oIllegal)
  );

  localparam int SG_IP = 0, SG_LED = 1, SG_VALID = 2, SG_ADDR = 3;
  localparam int SG_COLOR = 4, SG_BUSY = 5, SG_SERR = 6;
  localparam int SG_ILL = 7, SG_REG = 8;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] sig;
    logic [7:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int errors = 0;
  int checks = 0;
  int ready_from = 0;
  int busy_cnt, valid_cnt, xfer_cnt, ip_hit;

  function automatic logic [27:0] ins(logic [3:0] op, logic [7:0] d,
                                      logic [7:0] s1, logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [31:0] observe(int s, logic [7:0] idx);
    case (s)
      SG_IP:    return 32'(oIP);
      SG_LED:   return 32'(oLed);
      SG_VALID: return 32'(oVGAValid);
      SG_ADDR:  return 32'(oVGAAddr);
      SG_COLOR: return 32'(oVGAColor);
      SG_BUSY:  return 32'(oBusy);
      SG_SERR:  return 32'(oStackErr);
      SG_ILL:   return 32'(oIllegal);
      default:  return 32'(dut.r_rf[idx]);
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int c, int s, logic [7:0] idx,
                      logic [31:0] v, string t);
    exp_t e;
    e.cyc = 32'(c);
    e.sig = 32'(s);
    e.idx = idx;
    e.val = v;
    sb.push_back(e);
    tags.push_back(t);
  endtask

  task automatic restart();
    Reset = 1'b0;
    iVGAReady = 1'b1;
    ready_from = 0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    repeat (2) @(negedge Clock);
  endtask

  // Cycle k is sampled just after the k-th rising edge since release.
  task automatic run(int n, logic [15:0] watch_ip);
    exp_t  e;
    string t;
    busy_cnt = 0;
    valid_cnt = 0;
    xfer_cnt = 0;
    ip_hit = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge Clock);
      iVGAReady = (k >= ready_from);
      #1;
      if (oBusy) busy_cnt++;
      if (oVGAValid) valid_cnt++;
      if (oVGAValid && iVGAReady) xfer_cnt++;
      if (ip_hit == 0 && oIP == watch_ip) ip_hit = k;
      while (sb.size() > 0 && sb[0].cyc == 32'(k)) begin
        e = sb.pop_front();
        t = tags.pop_front();
        chk(t, observe(int'(e.sig), e.idx), e.val);
      end
    end
    chk("scoreboard_left", 32'(sb.size()), 0);
    sb.delete();
    tags.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    @(negedge Clock);
    #1;
    chk("rst_ip", 32'(oIP), 0);
    chk("rst_led", 32'(oLed), 0);
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_valid", 32'(oVGAValid), 0);
    chk("rst_addr", 32'(oVGAAddr), 0);
    chk("rst_color", 32'(oVGAColor), 0);
    chk("rst_serr", 32'(oStackErr), 0);
    chk("rst_ill", 32'(oIllegal), 0);

    // STO/STO/ADD/LED
    restart();
    rom[0] = ins(4'h3, 8'd1, 8'h00, 8'h05);
    rom[1] = ins(4'h3, 8'd2, 8'h00, 8'h07);
    rom[2] = ins(4'h4, 8'd3, 8'd1, 8'd2);
    rom[3] = ins(4'h1, 8'd0, 8'd3, 8'd0);
    push(4, SG_REG, 8'd3, 32'h000C, "add_r3");
    push(4, SG_LED, 0, 32'h00, "led_pre");
    push(5, SG_IP, 0, 32'd5, "ip_after5");
    push(5, SG_LED, 0, 32'h0C, "led_add");
    Reset = 1'b1;
    run(6, 16'hFFFF);

    // BLE taken with one bubble
    restart();
    rom[0] = ins(4'h3, 8'd1, 8'h00, 8'h03);
    rom[1] = ins(4'h3, 8'd2, 8'h00, 8'h09);
    rom[2] = ins(4'h2, 8'h20, 8'd1, 8'd2);
    rom[3] = ins(4'h1, 8'd0, 8'd1, 8'd0);
    rom[8'h20] = ins(4'h1, 8'd0, 8'd2, 8'd0);
    push(4, SG_IP, 0, 32'h20, "ble_tgt_ip");
    push(5, SG_IP, 0, 32'h21, "ble_tgt_ip1");
    push(5, SG_LED, 0, 32'h00, "ble_bubble_led");
    push(6, SG_LED, 0, 32'h09, "ble_tgt_led");
    Reset = 1'b1;
    run(7, 16'hFFFF);

    // BLE not taken
    restart();
    rom[0] = ins(4'h3, 8'd1, 8'h00, 8'h09);
    rom[1] = ins(4'h3, 8'd2, 8'h00, 8'h03);
    rom[2] = ins(4'h2, 8'h20, 8'd1, 8'd2);
    rom[3] = ins(4'h1, 8'd0, 8'd1, 8'd0);
    rom[8'h20] = ins(4'h1, 8'd0, 8'd2, 8'd0);
    push(4, SG_IP, 0, 32'd4, "ble_fall_ip");
    push(5, SG_LED, 0, 32'h09, "ble_fall_led");
    Reset = 1'b1;
    run(6, 16'hFFFF);

    // BEQ taken, then SUB
    restart();
    rom[0] = ins(4'h3, 8'd1, 8'h00, 8'h07);
    rom[1] = ins(4'h3, 8'd2, 8'h00, 8'h07);
    rom[2] = ins(4'hB, 8'h30, 8'd1, 8'd2);
    rom[8'h30] = ins(4'h7, 8'd3, 8'd0, 8'd1);
    push(4, SG_IP, 0, 32'h30, "beq_tgt_ip");
    push(6, SG_REG, 8'd3, 32'h0FFF9, "sub_wrap");
    rom[0] = ins(4'h3, 8'd0, 8'h00, 8'h00);
    rom[3] = ins(4'h3, 8'd1, 8'h00, 8'h07);
    rom[4] = ins(4'h3, 8'd2, 8'h00, 8'h07);
    rom[5] = ins(4'hB, 8'h30, 8'd1, 8'd2);
    rom[1] = ins(4'h3, 8'd1, 8'h00, 8'h07);
    rom[2] = ins(4'hB, 8'h30, 8'd1, 8'd1);
    Reset = 1'b1;
    run(7, 16'hFFFF);

    // MUL 0x00FF*0x0101 then 0xFFFF*0xFFFF
    restart();
    rom[0] = ins(4'h3, 8'd5, 8'h00, 8'hFF);
    rom[1] = ins(4'h3, 8'd6, 8'h01, 8'h01);
    rom[2] = ins(4'h8, 8'd4, 8'd5, 8'd6);
    rom[3] = ins(4'h1, 8'd0, 8'd4, 8'd0);
    rom[4] = ins(4'h3, 8'd7, 8'hFF, 8'hFF);
    rom[5] = ins(4'h8, 8'd8, 8'd7, 8'd7);
    push(3, SG_BUSY, 0, 32'd1, "mul_busy_on");
    push(19, SG_IP, 0, 32'd3, "mul_ip_held");
    push(20, SG_REG, 8'd4, 32'hFFFF, "mul_r4");
    push(20, SG_BUSY, 0, 32'd0, "mul_busy_off");
    push(21, SG_LED, 0, 32'hFF, "mul_led");
    push(39, SG_REG, 8'd8, 32'h0001, "mul_r8");
    Reset = 1'b1;
    run(40, 16'd4);
    chk("mul_busy_cycles", 32'(busy_cnt), 32'd34);
    chk("mul_next_cycle", 32'(ip_hit), 32'd20);

    // VGA with ready low for three cycles
    restart();
    rom[0] = ins(4'h3, 8'd1, 8'h00, 8'h04);
    rom[1] = ins(4'h3, 8'd2, 8'h12, 8'h34);
    rom[2] = ins(4'h6, 8'hA0, 8'd1, 8'd2);
    rom[3] = ins(4'h1, 8'd0, 8'd2, 8'd0);
    ready_from = 6;
    for (int c = 3; c <= 6; c++) begin
      push(c, SG_VALID, 0, 32'd1, "vga_valid");
      push(c, SG_ADDR, 0, 32'h41234, "vga_addr");
      push(c, SG_COLOR, 0, 32'd5, "vga_color");
    end
    push(6, SG_IP, 0, 32'd3, "vga_ip_held");
    push(7, SG_VALID, 0, 32'd0, "vga_valid_off");
    push(7, SG_IP, 0, 32'd4, "vga_resume_ip");
    push(8, SG_LED, 0, 32'h34, "vga_after_led");
    Reset = 1'b1;
    run(9, 16'hFFFF);
    chk("vga_valid_cycles", 32'(valid_cnt), 32'd4);
    chk("vga_transfers", 32'(xfer_cnt), 32'd1);
    chk("vga_busy_cycles", 32'(busy_cnt), 32'd3);

    // Return stack overflow/underflow with depth 2
    restart();
    rom[8'h00] = ins(4'h9, 8'h10, 8'd0, 8'd0);
    rom[8'h10] = ins(4'h9, 8'h20, 8'd0, 8'd0);
    rom[8'h20] = ins(4'h9, 8'h30, 8'd0, 8'd0);
    rom[8'h21] = ins(4'hA, 8'd0, 8'd0, 8'd0);
    rom[8'h11] = ins(4'hA, 8'd0, 8'd0, 8'd0);
    rom[8'h01] = ins(4'hA, 8'd0, 8'd0, 8'd0);
    push(2, SG_IP, 0, 32'h10, "call1_ip");
    push(4, SG_IP, 0, 32'h20, "call2_ip");
    push(5, SG_SERR, 0, 32'd0, "serr_pre");
    push(6, SG_IP, 0, 32'h22, "call_full_ip");
    push(6, SG_SERR, 0, 32'd1, "serr_full");
    push(7, SG_IP, 0, 32'h11, "ret1_ip");
    push(9, SG_IP, 0, 32'h01, "ret2_ip");
    push(11, SG_IP, 0, 32'h03, "ret_empty_ip");
    push(11, SG_SERR, 0, 32'd1, "serr_sticky");
    Reset = 1'b1;
    run(12, 16'hFFFF);

    // Illegal opcode, then reset mid-MUL
    restart();
    rom[0] = ins(4'h3, 8'd4, 8'h00, 8'h11);
    rom[1] = ins(4'hE, 8'd4, 8'd4, 8'd0);
    rom[2] = ins(4'h3, 8'd5, 8'h00, 8'h03);
    rom[3] = ins(4'h3, 8'd6, 8'h00, 8'h05);
    rom[4] = ins(4'h8, 8'd4, 8'd5, 8'd6);
    push(2, SG_ILL, 0, 32'd0, "ill_pre");
    push(3, SG_ILL, 0, 32'd1, "ill_set");
    push(3, SG_LED, 0, 32'd0, "ill_led");
    push(3, SG_REG, 8'd4, 32'h0011, "ill_r4");
    push(9, SG_BUSY, 0, 32'd1, "mid_mul_busy");
    push(9, SG_ILL, 0, 32'd1, "ill_held");
    Reset = 1'b1;
    run(9, 16'hFFFF);
    #1;
    Reset = 1'b0;
    #1;
    chk("arst_ip", 32'(oIP), 0);
    chk("arst_busy", 32'(oBusy), 0);
    chk("arst_ill", 32'(oIllegal), 0);
    chk("arst_led", 32'(oLed), 0);
    chk("arst_valid", 32'(oVGAValid), 0);
    repeat (2) @(negedge Clock);
    chk("arst_r4_kept", 32'(dut.r_rf[4]), 32'h0011);
    push(2, SG_IP, 0, 32'd2, "restart_ip");
    Reset = 1'b1;
    run(2, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
